// File: rtl/vid_timing_rx.sv
// vid_timing_rx: measures an incoming raster (totals, active sizes, sync
// polarities) on the pixel clock, declares lock after a run of identical
// frames and reports format changes or loss of signal.
module vid_timing_rx #(
    parameter int CNT_W       = 12,
    parameter int LOCK_FRAMES = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cen_i,
    input  logic [1:0]       vh_blank_i,
    input  logic [2:0]       dvh_sync_i,
    output logic [CNT_W-1:0] h_total_o,
    output logic [CNT_W-1:0] h_active_o,
    output logic [CNT_W-1:0] v_total_o,
    output logic [CNT_W-1:0] v_active_o,
    output logic             hs_pol_o,
    output logic             vs_pol_o,
    output logic             locked_o,
    output logic             frame_p_o,
    output logic             fmt_chg_p_o
);

    localparam logic [CNT_W-1:0] MAX    = '1;
    localparam logic [CNT_W-1:0] MAX_M1 = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [3:0]       LOCK_N = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

    typedef struct packed {
        logic [CNT_W-1:0] h_tot;
        logic [CNT_W-1:0] h_act;
        logic [CNT_W-1:0] v_tot;
        logic [CNT_W-1:0] v_act;
        logic             hs_pol;
        logic             vs_pol;
    } rec_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == MAX) ? v : v + ONE;
    endfunction

    // D_sync carries no timing information here
    logic unused_dsync;
    assign unused_dsync = dvh_sync_i[2];

    logic hs, vs, hb, vb, act_px;
    assign hs     = dvh_sync_i[0];
    assign vs     = dvh_sync_i[1];
    assign hb     = vh_blank_i[0];
    assign vb     = vh_blank_i[1];
    assign act_px = ~hb & ~vb;

    // measurement state
    logic             hs_q, vs_q;
    logic             pol_h, pol_v;       // inactive sync levels
    logic [CNT_W-1:0] hc, ha, vc, va;
    logic [CNT_W-1:0] line_len, ha_lat;
    logic             line_act;

    // control state
    state_t           state;
    logic [3:0]       match_cnt;
    rec_t             prev_rec, out_rec;

    logic             hle, vle, loss;
    rec_t             rec_now;
    logic [3:0]       match_nxt;

    // Edge detection, the record as it would close on this sample (line
    // closes first when HLE and VLE coincide) and the loss condition.
    always_comb begin
        hle            = cen_i & (hs_q == pol_h) & (hs != pol_h);
        vle            = cen_i & (vs_q == pol_v) & (vs != pol_v);
        rec_now.h_tot  = hle ? hc : line_len;
        rec_now.h_act  = hle ? ha : ha_lat;
        rec_now.v_tot  = hle ? sat_inc(vc) : vc;
        rec_now.v_act  = (hle && line_act) ? sat_inc(va) : va;
        rec_now.hs_pol = ~pol_h;
        rec_now.vs_pol = ~pol_v;
        // fires once, on the sample where a counter runs into all-ones
        loss           = cen_i & ((~hle & (hc == MAX_M1)) | (hle & (vc == MAX_M1)));
        match_nxt      = ((match_cnt == 4'd0) || (rec_now == prev_rec)) ?
                         match_cnt + 4'd1 : 4'd1;
    end

    // Pixel/line counters, line latches and polarity tracking
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            pol_h    <= 1'b0;
            pol_v    <= 1'b0;
            hc       <= '0;
            ha       <= '0;
            vc       <= '0;
            va       <= '0;
            line_len <= '0;
            ha_lat   <= '0;
            line_act <= 1'b0;
        end else if (cen_i) begin
            hs_q <= hs;
            vs_q <= vs;
            if (act_px) begin
                pol_h <= hs;
                pol_v <= vs;
            end
            if (hle) begin
                hc       <= ONE;
                line_len <= hc;
                ha_lat   <= ha;
                ha       <= hb ? '0 : ONE;
                line_act <= act_px;
            end else begin
                hc <= sat_inc(hc);
                if (!hb)
                    ha <= sat_inc(ha);
                if (act_px)
                    line_act <= 1'b1;
            end
            vc <= vle ? '0 : rec_now.v_tot;
            va <= vle ? '0 : rec_now.v_act;
        end
    end

    // Lock state machine with registered outputs and one-cycle pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= SEARCH;
            match_cnt   <= 4'd0;
            prev_rec    <= '0;
            out_rec     <= '0;
            locked_o    <= 1'b0;
            frame_p_o   <= 1'b0;
            fmt_chg_p_o <= 1'b0;
        end else begin
            frame_p_o   <= 1'b0;
            fmt_chg_p_o <= 1'b0;
            if (loss) begin
                fmt_chg_p_o <= (state == LOCKED);
                state       <= SEARCH;
                match_cnt   <= 4'd0;
                out_rec     <= '0;
                locked_o    <= 1'b0;
            end else if (vle) begin
                case (state)
                    SEARCH: begin
                        // partial frame before this edge is not measured
                        state     <= ACQUIRE;
                        match_cnt <= 4'd0;
                    end
                    ACQUIRE: begin
                        prev_rec  <= rec_now;
                        frame_p_o <= 1'b1;
                        match_cnt <= match_nxt;
                        if (match_nxt >= LOCK_N) begin
                            state    <= LOCKED;
                            out_rec  <= rec_now;
                            locked_o <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        frame_p_o <= 1'b1;
                        if (rec_now != prev_rec) begin
                            // outputs keep the last good format while reacquiring
                            state       <= ACQUIRE;
                            match_cnt   <= 4'd1;
                            prev_rec    <= rec_now;
                            locked_o    <= 1'b0;
                            fmt_chg_p_o <= 1'b1;
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end
        end
    end

    assign h_total_o  = out_rec.h_tot;
    assign h_active_o = out_rec.h_act;
    assign v_total_o  = out_rec.v_tot;
    assign v_active_o = out_rec.v_act;
    assign hs_pol_o   = out_rec.hs_pol;
    assign vs_pol_o   = out_rec.vs_pol;

endmodule

// File: tb/tb_vid_timing_rx.sv
// tb_vid_timing_rx: directed raster stimulus for vid_timing_rx with
// hand-computed expected measurements.
module tb_vid_timing_rx;

    logic        clk = 1'b0;
    logic        rst, cen;
    logic [1:0]  vh_blank;
    logic [2:0]  dvh_sync;
    logic [11:0] h_total, h_active, v_total, v_active;
    logic        hs_pol, vs_pol, locked, frame_p, fmt_chg_p;

    int   n_assert, n_fail;
    int   frame_cnt, fmt_cnt, cyc, lk_cyc;
    logic lk_first;

    vid_timing_rx #(.CNT_W(12), .LOCK_FRAMES(3)) dut (
        .clk_i(clk), .rst_i(rst), .cen_i(cen),
        .vh_blank_i(vh_blank), .dvh_sync_i(dvh_sync),
        .h_total_o(h_total), .h_active_o(h_active),
        .v_total_o(v_total), .v_active_o(v_active),
        .hs_pol_o(hs_pol), .vs_pol_o(vs_pol), .locked_o(locked),
        .frame_p_o(frame_p), .fmt_chg_p_o(fmt_chg_p)
    );

    always #5 clk = ~clk;

    // Run-length guard
    initial begin
        #1500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    localparam logic [63:0] SMALL_LK   = {13'd0, 12'd40, 12'd32, 12'd12, 12'd8, 3'b111};
    localparam logic [63:0] SMALL_HELD = {13'd0, 12'd40, 12'd32, 12'd12, 12'd8, 3'b110};
    localparam logic [63:0] SMALL_INV  = {13'd0, 12'd40, 12'd32, 12'd12, 12'd8, 3'b001};
    localparam logic [63:0] WIDE_LK    = {13'd0, 12'd2200, 12'd1920, 12'd4, 12'd2, 3'b111};

    function automatic logic [63:0] outs();
        return {13'd0, h_total, h_active, v_total, v_active, hs_pol, vs_pol, locked};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive a sample, let the DUT take it, observe #1 later
    task automatic px(input logic hs, input logic vs, input logic hb, input logic vb,
                      input logic ce);
        cen      = ce;
        dvh_sync = {1'b0, vs, hs};
        vh_blank = {vb, hb};
        @(posedge clk);
        #1;
        cyc++;
        frame_cnt += int'(frame_p);
        fmt_cnt   += int'(fmt_chg_p);
    endtask

    // Lines y0..y1-1 of a raster; sync pulses sit at the start of blanking,
    // so the VLE coincides with the HLE of line 0.
    task automatic frame(input int ht, input int ha, input int vt, input int va,
                         input logic hp, input logic vp, input logic alt,
                         input int y0, input int y1);
        for (int y = y0; y < y1; y++) begin
            for (int x = 0; x < ht; x++) begin
                logic hs, vs, hb, vb;
                hs = (x < 4) ? hp : ~hp;
                vs = (y < 2) ? vp : ~vp;
                hb = (x < ht - ha);
                vb = (y < vt - va);
                px(hs, vs, hb, vb, 1'b1);
                if (x == 0 && y == 0) begin
                    lk_first = locked;
                    lk_cyc   = cyc;
                end
                if (alt)
                    px(hs, vs, hb, vb, 1'b0);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        px(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        rst       = 1'b0;
        frame_cnt = 0;
        fmt_cnt   = 0;
        cyc       = 0;
    endtask

    initial begin
        rst = 1'b0; cen = 1'b0; vh_blank = 2'b11; dvh_sync = 3'b000;
        n_assert = 0; n_fail = 0; frame_cnt = 0; fmt_cnt = 0; cyc = 0;
        lk_cyc = 0; lk_first = 1'b0;

        // Reset state
        do_reset();
        chk("reset_outs", outs(), 64'd0);
        chk("reset_pulses", {62'd0, frame_p, fmt_chg_p}, 64'd0);

        // Small raster, cen always high
        repeat (3) frame(40, 32, 12, 8, 1'b1, 1'b1, 1'b0, 0, 12);
        chk("t1_frames_pre", frame_cnt, 2);
        chk("t1_unlocked_pre", locked, 0);
        frame(40, 32, 12, 8, 1'b1, 1'b1, 1'b0, 0, 12);
        chk("t1_lock_vle4", lk_first, 1);
        chk("t1_lock_cycle", lk_cyc, 1441);
        chk("t1_frames", frame_cnt, 3);
        chk("t1_values", outs(), SMALL_LK);

        // Same raster, cen alternating
        do_reset();
        repeat (3) frame(40, 32, 12, 8, 1'b1, 1'b1, 1'b1, 0, 12);
        chk("t2_frames_pre", frame_cnt, 2);
        chk("t2_unlocked_pre", locked, 0);
        frame(40, 32, 12, 8, 1'b1, 1'b1, 1'b1, 0, 12);
        chk("t2_lock_vle4", lk_first, 1);
        chk("t2_lock_cycle", lk_cyc, 2881);
        chk("t2_values", outs(), SMALL_LK);

        // One 41-pixel frame while locked, then back to 40
        frame(41, 32, 12, 8, 1'b1, 1'b1, 1'b0, 0, 12);
        chk("t3_no_chg_yet", fmt_cnt, 0);
        frame(40, 32, 12, 8, 1'b1, 1'b1, 1'b0, 0, 12);
        chk("t3_fmt_chg", fmt_cnt, 1);
        chk("t3_held", outs(), SMALL_HELD);
        repeat (2) frame(40, 32, 12, 8, 1'b1, 1'b1, 1'b0, 0, 12);
        chk("t3_unlocked_3rd", lk_first, 0);
        frame(40, 32, 12, 8, 1'b1, 1'b1, 1'b0, 0, 12);
        chk("t3_relock", lk_first, 1);
        chk("t3_values", outs(), SMALL_LK);
        chk("t3_single_chg", fmt_cnt, 1);

        // Hsync stuck inactive: hc is 40 here, saturates after 4055 samples
        repeat (4054) px(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("t4_locked_before_sat", locked, 1);
        px(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("t4_loss_pulse", fmt_cnt, 2);
        chk("t4_cleared", outs(), 64'd0);
        repeat (50) px(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("t4_single_pulse", fmt_cnt, 2);

        // Reset mid-frame while reacquiring with held outputs
        do_reset();
        repeat (4) frame(40, 32, 12, 8, 1'b1, 1'b1, 1'b0, 0, 12);
        frame(41, 32, 12, 8, 1'b1, 1'b1, 1'b0, 0, 12);
        frame(40, 32, 12, 8, 1'b1, 1'b1, 1'b0, 0, 6);
        chk("t5_acquire_held", outs(), SMALL_HELD);
        do_reset();
        chk("t5_reset_outs", outs(), 64'd0);
        frame(40, 32, 12, 8, 1'b1, 1'b1, 1'b0, 6, 12);
        repeat (3) frame(40, 32, 12, 8, 1'b1, 1'b1, 1'b0, 0, 12);
        chk("t5_frames_pre", frame_cnt, 2);
        chk("t5_unlocked_pre", locked, 0);
        frame(40, 32, 12, 8, 1'b1, 1'b1, 1'b0, 0, 1);
        chk("t5_lock_4th", lk_first, 1);

        // 1080p line timing on a short frame to keep the run length down
        do_reset();
        repeat (3) frame(2200, 1920, 4, 2, 1'b1, 1'b1, 1'b0, 0, 4);
        chk("t6_unlocked_pre", locked, 0);
        frame(2200, 1920, 4, 2, 1'b1, 1'b1, 1'b0, 0, 1);
        chk("t6_lock", lk_first, 1);
        chk("t6_values", outs(), WIDE_LK);

        // Sync inversion after lock
        do_reset();
        repeat (4) frame(40, 32, 12, 8, 1'b1, 1'b1, 1'b0, 0, 12);
        chk("t7_locked_pos", outs(), SMALL_LK);
        frame(40, 32, 12, 8, 1'b0, 1'b0, 1'b0, 0, 12);
        chk("t7_fmt_chg", fmt_cnt, 1);
        chk("t7_unlocked", locked, 0);
        for (int i = 0; i < 8 && !locked; i++)
            frame(40, 32, 12, 8, 1'b0, 1'b0, 1'b0, 0, 12);
        chk("t7_relock_neg", outs(), SMALL_INV);
        chk("t7_single_chg", fmt_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/vid_timing_rx.md
# vid_timing_rx

Receive-side video timing analyser for the {D_sync, Vsync, Hsync} / {Vblank, Hblank} pixel interface used between the pattern source, the unit under test and the HDMI TX path. It measures the incoming raster (totals, active sizes and sync polarities) on the video pixel clock. It declares lock after a run of identical frames and flags format changes or signal loss. Its outputs feed the VIO debug probes and the format checks on the UUT output.

## Interface
- CNT_W, 12, width of all pixel/line counters and measurement outputs; maximum measurable value 2^CNT_W-1
- LOCK_FRAMES, 3, consecutive identical frame measurements required to assert lock (range 1..15)

Ports:
- clk_i  in  1  video pixel clock
- rst_i  in  1  reset, synchronous, active-high
- cen_i  in  1  pixel clock enable; all inputs sampled and all counters advance only when high
- vh_blank_i  in  2  {Vblank, Hblank}, active-high
- dvh_sync_i  in  3  {D_sync, Vsync, Hsync}; D_sync ignored
- h_total_o  out  CNT_W  pixels per line
- h_active_o  out  CNT_W  active pixels per line (last complete line of frame)
- v_total_o  out  CNT_W  lines per frame
- v_active_o  out  CNT_W  active lines per frame
- hs_pol_o  out  1  1 = Hsync active-high
- vs_pol_o  out  1  1 = Vsync active-high
- locked_o  out  1  raster stable
- frame_p_o  out  1  one-cycle pulse per measured frame
- fmt_chg_p_o  out  1  one-cycle pulse on loss of lock

## Operation
- All logic is gated by cen_i; a cycle with cen_i=0 changes no state, except that single-cycle pulses clear.
- Polarity: on every cen cycle with Hblank=0 and Vblank=0, latch pol_h = Hsync and pol_v = Vsync as the inactive levels. The active level is the inverse, so hs_pol_o = ~pol_h and vs_pol_o = ~pol_v. Until the first active pixel is seen, the polarity is taken as active-high.
- Hsync leading edge (HLE): a Hsync transition from inactive to active level between consecutive cen samples. The Vsync leading edge (VLE) is defined the same way.
- Pixel counter hc: reloads to 1 on HLE, otherwise increments. On HLE the previous hc value is latched as line_len.
- Active pixel counter ha: counts Hblank=0 samples within the line, is latched on HLE, and clears.
- Line counter vc: increments on HLE, reloads to 0 on VLE.
- Active line counter va: increments on HLE when the line just ended contained at least one sample with Hblank=0 and Vblank=0.
- On VLE, the frame record {line_len, ha_latched, vc, va, pols} is complete. Exception: the first VLE after SEARCH only arms measurement.
- Counters saturate at all-ones. Saturation of hc or vc is a loss event.
- State machine:
  - SEARCH → ACQUIRE on the first VLE. match_cnt is set to 0.
  - ACQUIRE, on each VLE:
    - If the record equals the previous record, or it is the first record, match_cnt increments.
    - Otherwise match_cnt is set to 1.
    - The record is stored and frame_p_o pulses.
    - When match_cnt reaches LOCK_FRAMES, go to LOCKED and load the outputs from the record.
  - LOCKED, on each VLE with an equal record: frame_p_o pulses and the outputs are unchanged.
  - LOCKED, on a VLE with an unequal record: go to ACQUIRE with match_cnt=1, the record stored, locked_o=0, fmt_chg_p_o pulses, and the outputs are held.
  - A loss event in any state goes to SEARCH with all outputs cleared. fmt_chg_p_o pulses only if the state was LOCKED.
- A VLE and an HLE on the same sample: the HLE is processed first, so the line closes and counts into vc/va, then the VLE closes the frame.

## Timing
- Reset values: all outputs 0, state SEARCH, all counters 0, polarity latches set for active-high.
- Latency: on the cen sample carrying a VLE, state, outputs, locked_o and frame_p_o update on the next clk_i edge (1 cycle).
- frame_p_o and fmt_chg_p_o are high for exactly one clk_i cycle regardless of cen_i.
- Measurement outputs change only on entry to LOCKED or on a loss event. They are stable whenever locked_o=1.
- rst_i mid-frame: next cycle equals the reset state, and the partial frame is discarded.

## Test plan
- Small raster, cen_i=1: h_total 40, h_active 32, v_total 12, v_active 8, sync active-high, LOCK_FRAMES=3.
  - Required response: frame_p_o on VLE #2, #3 and #4.
  - locked_o rises one cycle after VLE #4.
  - Outputs read 40/32/12/8 with hs_pol=vs_pol=1.
- Same raster with cen_i alternating 1/0:
  - Identical measured values.
  - Lock at the same VLE count; wall time is doubled.
- 1080p60 raster (2200/1920/1125/1080, active-high syncs), then the same raster with both syncs inverted after lock:
  - Values are 2200/1920/1125/1080 with pol 1/1.
  - After the inversion, fmt_chg_p_o fires, then relock with pol 0/0.
- Locked small raster, then one frame with h_total 41, then 40 again:
  - fmt_chg_p_o on the 41 frame; outputs held, locked_o=0.
  - Relock after 3 matching frames.
- Locked raster, then Hsync stuck inactive:
  - After 4095 pixels, state SEARCH, all outputs 0, single fmt_chg_p_o.
- rst_i asserted mid-frame while in ACQUIRE:
  - Next cycle all outputs 0.
  - Lock requires 4 further VLEs.
